// File: rtl/cpu_bus_sequencer.sv
// M-cycle bus sequencer: owns T-cycle timing and drives the system bus for the SM83 core.
// Define CPU_BUS_WAIT_EN to honour bus_wait with wait-state stretching and a MAX_WAIT timeout.
module cpu_bus_sequencer #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned TCYC     = 4,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              req_valid_i,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              req_ready_o,
   output logic [2:0]        t_cycle_o,
   output logic              clk_phi_o,
   output logic              m_end_o,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic              bus_enable_o,
   output logic              bus_write_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_wait_i
);

   localparam int unsigned   TW    = $clog2(TCYC);
   localparam logic [TW-1:0] TLast = TW'(TCYC - 1);
   localparam logic [TW-1:0] THalf = TW'(TCYC / 2);

   typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

   state_e            state_q;
   logic [TW-1:0]     tcnt_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] bus_addr_q;
   logic              bus_enable_q;
   logic              bus_write_q;
   logic [DATA_W-1:0] bus_wdata_q;

   logic busy, last, stall, timeout, done;

   assign busy = (state_q != StIdle);
   assign last = (tcnt_q == TLast);

`ifdef CPU_BUS_WAIT_EN
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   logic [WW-1:0] wcnt_q;

   assign timeout = (state_q == StWait) && bus_wait_i && (wcnt_q == WW'(MAX_WAIT));
   assign stall   = busy && last && bus_wait_i && !timeout;

   // wcnt counts every stalled clk, including the first one seen in ACCESS
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         wcnt_q <= '0;
      end else if (stall) begin
         wcnt_q <= (state_q == StAccess) ? WW'(1) : wcnt_q + 1'b1;
      end else if (done || timeout) begin
         wcnt_q <= '0;
      end
   end
`else
   localparam int unsigned unused_max_wait = MAX_WAIT;
   logic unused_wait;
   assign unused_wait = bus_wait_i;
   assign timeout     = 1'b0;
   assign stall       = 1'b0;
`endif

   assign done = busy && last && !stall && !timeout;

   assign req_ready_o  = req_valid_i && (tcnt_q == '0) && !stall;
   assign t_cycle_o    = 3'(tcnt_q);
   assign clk_phi_o    = (tcnt_q < THalf);
   assign m_end_o      = last && !stall;
   assign rsp_valid_o  = done && !bus_write_q;
   assign rsp_err_o    = timeout;
   // Completing read forwards the bus data in the same clk as rsp_valid
   assign rsp_rdata_o  = rsp_valid_o ? bus_rdata_i : rdata_q;
   assign bus_addr_o   = bus_addr_q;
   assign bus_enable_o = bus_enable_q;
   assign bus_write_o  = bus_write_q;
   assign bus_wdata_o  = bus_wdata_q;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q      <= StIdle;
         tcnt_q       <= '0;
         rdata_q      <= '0;
         bus_addr_q   <= '0;
         bus_enable_q <= 1'b0;
         bus_write_q  <= 1'b0;
         bus_wdata_q  <= '0;
      end else begin
         if (!stall) begin
            tcnt_q <= last ? '0 : tcnt_q + 1'b1;
         end
         case (state_q)
            StIdle: begin
               if (req_ready_o) begin
                  state_q      <= StAccess;
                  bus_addr_q   <= req_addr_i;
                  bus_enable_q <= 1'b1;
                  bus_write_q  <= req_write_i;
                  bus_wdata_q  <= req_write_i ? req_wdata_i : '0;
               end
            end
            StAccess, StWait: begin
               if (done || timeout) begin
                  state_q      <= StIdle;
                  bus_addr_q   <= '0;
                  bus_enable_q <= 1'b0;
                  bus_write_q  <= 1'b0;
                  bus_wdata_q  <= '0;
                  if (done && !bus_write_q) begin
                     rdata_q <= bus_rdata_i;
                  end
               end else if (stall) begin
                  state_q <= StWait;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Directed bench for cpu_bus_sequencer: a TCYC=4 instance for reads, writes, waits and reset,
// and a TCYC=2 instance for back-to-back reads.
module tb_cpu_bus_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rv4, rv2, req_write;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata, bus_rdata;
   logic        bus_wait;

   logic        ready4, phi4, mend4, rspv4, err4, en4, wr4;
   logic [2:0]  tc4;
   logic [7:0]  rdata4, wdata4;
   logic [15:0] addr4;

   logic        ready2, phi2, mend2, rspv2, err2, en2, wr2;
   logic [2:0]  tc2;
   logic [7:0]  rdata2, wdata2;
   logic [15:0] addr2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cpu_bus_sequencer #(.ADDR_W(16), .DATA_W(8), .TCYC(4), .MAX_WAIT(15)) u_dut4 (
      .clk_i(clk), .reset_ni(reset_n), .req_valid_i(rv4), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ready_o(ready4), .t_cycle_o(tc4),
      .clk_phi_o(phi4), .m_end_o(mend4), .rsp_valid_o(rspv4), .rsp_rdata_o(rdata4),
      .rsp_err_o(err4), .bus_addr_o(addr4), .bus_enable_o(en4), .bus_write_o(wr4),
      .bus_wdata_o(wdata4), .bus_rdata_i(bus_rdata), .bus_wait_i(bus_wait)
   );

   cpu_bus_sequencer #(.ADDR_W(16), .DATA_W(8), .TCYC(2), .MAX_WAIT(15)) u_dut2 (
      .clk_i(clk), .reset_ni(reset_n), .req_valid_i(rv2), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ready_o(ready2), .t_cycle_o(tc2),
      .clk_phi_o(phi2), .m_end_o(mend2), .rsp_valid_o(rspv2), .rsp_rdata_o(rdata2),
      .rsp_err_o(err2), .bus_addr_o(addr2), .bus_enable_o(en2), .bus_write_o(wr2),
      .bus_wdata_o(wdata2), .bus_rdata_i(bus_rdata), .bus_wait_i(bus_wait)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge, outputs are checked 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; rv4 = 1'b0; rv2 = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; bus_rdata = '0; bus_wait = 1'b0;
      tick(); tick(); #1;
      chk("rst_tcycle", tc4, 0);
      chk("rst_enable", en4, 0);
      chk("rst_addr", addr4, 0);
      chk("rst_mend", mend4, 0);
      chk("rst_rdata", rdata4, 0);
      chk("rst_ready", ready4, 0);

      // Read 0xC000, slave returns 0x5A
      reset_n = 1'b1; rv4 = 1'b1; req_addr = 16'hC000; #1;
      chk("rd_ready_t0", ready4, 1);
      tick(); rv4 = 1'b0; #1;
      chk("rd_en_t1", en4, 1);
      chk("rd_addr_t1", addr4, 16'hC000);
      chk("rd_tcycle_t1", tc4, 1);
      chk("rd_mend_t1", mend4, 0);
      chk("rd_phi_t1", phi4, 1);
      tick(); #1;
      chk("rd_en_t2", en4, 1);
      chk("rd_phi_t2", phi4, 0);
      tick(); bus_rdata = 8'h5A; #1;
      chk("rd_mend_t3", mend4, 1);
      chk("rd_rspv_t3", rspv4, 1);
      chk("rd_rdata_t3", rdata4, 8'h5A);
      chk("rd_en_t3", en4, 1);

      // Write 0xA5 to 0xFF80, issued back-to-back
      tick(); bus_rdata = 8'h00; rv4 = 1'b1; req_write = 1'b1; req_addr = 16'hFF80;
      req_wdata = 8'hA5; #1;
      chk("rd_en_drop", en4, 0);
      chk("rd_rspv_drop", rspv4, 0);
      chk("rd_rdata_hold", rdata4, 8'h5A);
      chk("wr_ready_t0", ready4, 1);
      tick(); rv4 = 1'b0; req_write = 1'b0; req_wdata = 8'h00; #1;
      chk("wr_write_t1", wr4, 1);
      chk("wr_wdata_t1", wdata4, 8'hA5);
      chk("wr_addr_t1", addr4, 16'hFF80);
      tick(); #1;
      chk("wr_write_t2", wr4, 1);
      tick(); #1;
      chk("wr_mend_t3", mend4, 1);
      chk("wr_rspv_t3", rspv4, 0);
      chk("wr_write_t3", wr4, 1);
      chk("wr_rdata_kept", rdata4, 8'h5A);
      tick(); #1;
      chk("wr_write_drop", wr4, 0);
      chk("wr_wdata_drop", wdata4, 0);
      chk("wr_tcycle_t0", tc4, 0);

`ifdef CPU_BUS_WAIT_EN
      // Two wait clks at T3
      rv4 = 1'b1; req_addr = 16'h1234; #1;
      tick(); rv4 = 1'b0; #1;
      tick(); #1;
      tick(); bus_wait = 1'b1; #1;
      chk("w2_mend_c3", mend4, 0);
      chk("w2_tcycle_c3", tc4, 3);
      tick(); #1;
      chk("w2_mend_c4", mend4, 0);
      chk("w2_tcycle_c4", tc4, 3);
      chk("w2_en_c4", en4, 1);
      tick(); bus_wait = 1'b0; bus_rdata = 8'h3C; #1;
      chk("w2_mend_c5", mend4, 1);
      chk("w2_rspv_c5", rspv4, 1);
      chk("w2_rdata_c5", rdata4, 8'h3C);
      chk("w2_tcycle_c5", tc4, 3);
      tick(); bus_rdata = 8'h00; #1;
      chk("w2_tcycle_c6", tc4, 0);
      chk("w2_en_c6", en4, 0);

      // bus_wait stuck high: timeout after 15 wait clks
      rv4 = 1'b1; req_addr = 16'h4000; #1;
      tick(); rv4 = 1'b0; #1;
      tick(); #1;
      tick(); bus_wait = 1'b1; bus_rdata = 8'h77; #1;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) begin
            tick(); #1;
         end
         chk("to_mend_wait", mend4, 0);
         chk("to_err_wait", err4, 0);
      end
      tick(); #1;
      chk("to_err", err4, 1);
      chk("to_mend", mend4, 1);
      chk("to_rspv", rspv4, 0);
      chk("to_rdata_kept", rdata4, 8'h3C);
      tick(); bus_wait = 1'b0; bus_rdata = 8'h00; rv4 = 1'b1; req_addr = 16'h0001; #1;
      chk("to_err_drop", err4, 0);
      chk("to_en_drop", en4, 0);
      chk("to_tcycle", tc4, 0);
      chk("to_ready_idle", ready4, 1);
      tick(); rv4 = 1'b0; #1;
      chk("to_next_en", en4, 1);
      chk("to_next_addr", addr4, 16'h0001);
      tick(); #1;
      tick(); bus_rdata = 8'h99; #1;
      chk("to_next_rspv", rspv4, 1);
      tick(); bus_rdata = 8'h00; #1;
`else
      // bus_wait is ignored: access still ends at T3
      rv4 = 1'b1; req_addr = 16'h1234; #1;
      tick(); rv4 = 1'b0; #1;
      tick(); #1;
      tick(); bus_wait = 1'b1; bus_rdata = 8'h3C; #1;
      chk("nw_mend_t3", mend4, 1);
      chk("nw_rspv_t3", rspv4, 1);
      chk("nw_err_t3", err4, 0);
      chk("nw_rdata_t3", rdata4, 8'h3C);
      tick(); bus_wait = 1'b0; bus_rdata = 8'h00; #1;
      chk("nw_tcycle_t0", tc4, 0);
      chk("nw_en_drop", en4, 0);
`endif

      // Reset during T2 of a read aborts it
      rv4 = 1'b1; req_addr = 16'h8000; #1;
      tick(); rv4 = 1'b0; #1;
      tick(); reset_n = 1'b0; bus_rdata = 8'hEE; #1;
      chk("rs_en_before", en4, 1);
      tick(); #1;
      chk("rs_tcycle", tc4, 0);
      chk("rs_en", en4, 0);
      chk("rs_addr", addr4, 0);
      chk("rs_mend", mend4, 0);
      chk("rs_rspv", rspv4, 0);
      chk("rs_err", err4, 0);
      chk("rs_rdata", rdata4, 0);
      reset_n = 1'b1; #1;
      for (int i = 1; i < 4; i++) begin
         tick(); #1;
         chk("rs_after_rspv", rspv4, 0);
         chk("rs_after_err", err4, 0);
         chk("rs_after_en", en4, 0);
      end
      chk("rs_internal_mend", mend4, 1);
      tick(); bus_rdata = 8'h00; #1;

      // TCYC=2: three back-to-back reads, req_valid held throughout
      rv2 = 1'b1; req_addr = 16'h0100; #1;
      chk("b2_ready_a0", ready2, 1);
      chk("b2_phi_a0", phi2, 1);
      chk("b2_mend_a0", mend2, 0);
      tick(); bus_rdata = 8'h11; #1;
      chk("b2_tcycle_a1", tc2, 1);
      chk("b2_en_a1", en2, 1);
      chk("b2_addr_a1", addr2, 16'h0100);
      chk("b2_mend_a1", mend2, 1);
      chk("b2_rspv_a1", rspv2, 1);
      chk("b2_rdata_a1", rdata2, 8'h11);
      chk("b2_phi_a1", phi2, 0);
      chk("b2_ready_a1", ready2, 0);
      tick(); bus_rdata = 8'h00; #1;
      chk("b2_ready_b0", ready2, 1);
      chk("b2_en_b0", en2, 0);
      chk("b2_rspv_b0", rspv2, 0);
      chk("b2_phi_b0", phi2, 1);
      tick(); bus_rdata = 8'h22; #1;
      chk("b2_rspv_b1", rspv2, 1);
      chk("b2_rdata_b1", rdata2, 8'h22);
      chk("b2_write_b1", wr2, 0);
      chk("b2_wdata_b1", wdata2, 0);
      tick(); bus_rdata = 8'h00; #1;
      chk("b2_ready_c0", ready2, 1);
      tick(); bus_rdata = 8'h33; #1;
      chk("b2_rspv_c1", rspv2, 1);
      chk("b2_mend_c1", mend2, 1);
      chk("b2_err_c1", err2, 0);
      tick(); rv2 = 1'b0; bus_rdata = 8'h00; #1;
      chk("b2_ready_idle", ready2, 0);
      chk("b2_rdata_hold", rdata2, 8'h33);
      chk("b2_tcycle_d0", tc2, 0);
      chk("b2_en_idle", en2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
